// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg : shared status type and sizing helper for fifo_v4_sram
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Occupancy width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_sdp.sv
// ---------------------------------------------------------------------------
// sram_sdp : simple dual-port RAM, one write port, registered read port
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_sdp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  // Array and read register carry no reset so the tools can map them to BRAM.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/fifo_v4_sram.sv
// ---------------------------------------------------------------------------
// fifo_v4_sram : FWFT FIFO on a 1-cycle-latency SDP RAM with 2-entry prefetch
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_v4_sram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 4,
  parameter int CNT_W      = cnt_w(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_empty_o,
  output logic                  almost_full_o,
  output logic [CNT_W-1:0]      usage_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] C_AE    = CNT_W'(AE_THRESH);

  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]      ram_cnt_q, ram_cnt_d;
  logic [CNT_W-1:0]      usage_q, usage_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  fwd_q, fwd_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic [DATA_WIDTH-1:0] pf_q [2];
  logic [DATA_WIDTH-1:0] pf_d [2];
  logic [1:0]            pf_cnt_q, pf_cnt_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;

  fifo_status_t          status;
  logic                  push_acc, pop_acc, bypass, ram_we, ram_re;
  logic [1:0]            pf_cnt_pop;
  logic                  in_vld;
  logic [DATA_WIDTH-1:0] in_data, ram_rdata;

  sram_sdp #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we & ~flush_i),
    .waddr_i (wptr_q),
    .wdata_i (data_i),
    .re_i    (ram_re & ~flush_i),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    status.empty        = (pf_cnt_q == 2'd0);
    status.full         = (usage_q == C_DEPTH);
    status.almost_empty = (usage_q <= C_AE);
    status.almost_full  = (usage_q >= C_AF);
    status.overflow     = ovf_q;
    status.underflow    = unf_q;

    push_acc   = push_i & ~status.full;
    pop_acc    = pop_i & ~status.empty;
    pf_cnt_pop = pf_cnt_q - {1'b0, pop_acc};
    bypass     = push_acc & (ram_cnt_q == '0) & ~rd_pend_q & (pf_cnt_pop < 2'd2);
    ram_we     = push_acc & ~bypass;
    // A write into an empty RAM may be read the same cycle; its data is
    // forwarded from a side register because the RAM returns the old word.
    ram_re     = ((ram_cnt_q != '0) | ram_we) &
                 (((pf_cnt_q + {1'b0, rd_pend_q}) < 2'd2) | pop_acc);

    in_vld  = rd_pend_q | bypass;
    in_data = bypass ? data_i : (fwd_q ? fwd_data_q : ram_rdata);

    pf_d     = pf_q;
    pf_cnt_d = pf_cnt_q;
    if (pop_acc) begin
      if (pf_cnt_q == 2'd2) pf_d[0] = pf_q[1];
      pf_cnt_d = pf_cnt_pop;
    end
    if (in_vld) begin
      pf_d[pf_cnt_d[0]] = in_data;
      pf_cnt_d          = pf_cnt_d + 2'd1;
    end

    wptr_d     = wptr_q + AW'(ram_we);
    rptr_d     = rptr_q + AW'(ram_re);
    ram_cnt_d  = ram_cnt_q + CNT_W'(ram_we) - CNT_W'(ram_re);
    rd_pend_d  = ram_re;
    fwd_d      = ram_re & ram_we & (ram_cnt_q == '0);
    fwd_data_d = fwd_d ? data_i : fwd_data_q;
    usage_d    = usage_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
    ovf_d      = ovf_q | (push_i & status.full);
    unf_d      = unf_q | (pop_i & status.empty);

    // Flush empties the queue and drops any in-flight read; error flags hold.
    if (flush_i) begin
      pf_d       = '{default: '0};
      pf_cnt_d   = 2'd0;
      wptr_d     = '0;
      rptr_d     = '0;
      ram_cnt_d  = '0;
      rd_pend_d  = 1'b0;
      fwd_d      = 1'b0;
      fwd_data_d = fwd_data_q;
      usage_d    = '0;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pf_q       <= '{default: '0};
      pf_cnt_q   <= 2'd0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      usage_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      pf_q       <= pf_d;
      pf_cnt_q   <= pf_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      rd_pend_q  <= rd_pend_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      usage_q    <= usage_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign data_o         = pf_q[0];
  assign empty_o        = status.empty;
  assign full_o         = status.full;
  assign almost_empty_o = status.almost_empty;
  assign almost_full_o  = status.almost_full;
  assign usage_o        = usage_q;
  assign overflow_o     = status.overflow;
  assign underflow_o    = status.underflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_v4_sram.sv
// ---------------------------------------------------------------------------
// tb_fifo_v4_sram : randomized bench with a queue-based reference model
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fifo_v4_sram;

  localparam int DW    = 36;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0, flush = 1'b0, push = 1'b0, pop = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          empty, full, ae, af, ovf, unf;
  logic [CW-1:0] usage;

  always #5 clk = ~clk;

  fifo_v4_sram #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .push_i         (push),
    .data_i         (din),
    .pop_i          (pop),
    .data_o         (dout),
    .empty_o        (empty),
    .full_o         (full),
    .almost_empty_o (ae),
    .almost_full_o  (af),
    .usage_o        (usage),
    .overflow_o     (ovf),
    .underflow_o    (unf)
  );

  // Reference model: contents as a plain queue, sticky errors, last head.
  logic [DW-1:0] q [$];
  bit            m_ovf = 1'b0, m_unf = 1'b0;
  logic [DW-1:0] m_head = '0;
  int            total = 0, bad = 0;

  function automatic logic [10:0] exp_stat();
    return {q.size() == 0, q.size() == DEPTH, q.size() <= AE, q.size() >= AF,
            m_ovf, m_unf, CW'(q.size())};
  endfunction

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic cycle(input bit r, input bit f, input bit p, input logic [DW-1:0] d, input bit o);
    bit pa, oa;
    rst = r; flush = f; push = p; din = d; pop = o;
    @(posedge clk);
    if (r) begin
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_head = '0;
    end else if (f) begin
      q.delete(); m_head = '0;
    end else begin
      pa = p && (q.size() < DEPTH);
      oa = o && (q.size() > 0);
      if (p && q.size() == DEPTH) m_ovf = 1'b1;
      if (o && q.size() == 0) m_unf = 1'b1;
      if (oa) void'(q.pop_front());
      if (pa) q.push_back(d);
      if (q.size() > 0) m_head = q[0];
    end
    #1;
    rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, '0, 0);
    cycle(1, 0, 0, '0, 0);
    total++;
    if ({empty, full, ae, af, ovf, unf, usage} !== {6'b101000, 5'd0}) begin
      bad++; $display("FAIL reset_flags got=%b want=%b", {empty, full, ae, af, ovf, unf, usage}, {6'b101000, 5'd0});
    end
    total++;
    if (dout !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", dout); end
    cycle(0, 0, 1, 36'hA5, 0);
    total++;
    if ({empty, dout, usage} !== {1'b0, 36'hA5, 5'd1}) begin
      bad++; $display("FAIL first_push got e=%b d=%h u=%0d want e=0 d=a5 u=1", empty, dout, usage);
    end
  endtask

  task automatic test_fill();
    cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 0, 1, DW'(i), 0);
      total++;
      if ({empty, full, ae, af, ovf, unf, usage} !== exp_stat()) begin
        bad++; $display("FAIL fill_stat i=%0d got=%b want=%b", i, {empty, full, ae, af, ovf, unf, usage}, exp_stat());
      end
      total++;
      if (dout !== m_head) begin bad++; $display("FAIL fill_head i=%0d got=%h want=%h", i, dout, m_head); end
    end
    cycle(0, 0, 1, 36'hDEAD, 0);
    total++;
    if ({full, ovf, usage} !== {1'b1, 1'b1, 5'd16}) begin
      bad++; $display("FAIL overflow got f=%b o=%b u=%0d want f=1 o=1 u=16", full, ovf, usage);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if ({empty, dout} !== {1'b0, DW'(i)}) begin
        bad++; $display("FAIL drain_head i=%0d got e=%b d=%h want e=0 d=%h", i, empty, dout, DW'(i));
      end
      cycle(0, 0, 0, '0, 1);
      total++;
      if ({empty, full, ae, af, ovf, unf, usage} !== exp_stat()) begin
        bad++; $display("FAIL drain_stat i=%0d got=%b want=%b", i, {empty, full, ae, af, ovf, unf, usage}, exp_stat());
      end
    end
    cycle(0, 0, 0, '0, 1);
    total++;
    if ({empty, unf, usage} !== {1'b1, 1'b1, 5'd0}) begin
      bad++; $display("FAIL underflow got e=%b u=%b n=%0d want e=1 u=1 n=0", empty, unf, usage);
    end
  endtask

  task automatic test_back_to_back();
    int lvls [2] = '{1, 8};
    cycle(1, 0, 0, '0, 0);
    foreach (lvls[k]) begin
      while (q.size() < lvls[k]) cycle(0, 0, 1, rnd(), 0);
      for (int i = 0; i < 100; i++) begin
        cycle(0, 0, 1, rnd(), 1);
        total++;
        if ({usage, empty, dout} !== {CW'(lvls[k]), 1'b0, m_head}) begin
          bad++; $display("FAIL b2b lvl=%0d i=%0d got u=%0d e=%b d=%h want u=%0d e=0 d=%h",
                          lvls[k], i, usage, empty, dout, lvls[k], m_head);
        end
      end
    end
  endtask

  task automatic test_flush();
    cycle(1, 0, 0, '0, 0);
    cycle(0, 0, 0, '0, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, rnd(), 0);
    cycle(0, 1, 1, rnd(), 1);
    total++;
    if ({empty, usage, ovf, unf} !== {1'b1, 5'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL flush got e=%b u=%0d o=%b n=%b want e=1 u=0 o=0 n=1", empty, usage, ovf, unf);
    end
    cycle(0, 0, 1, 36'h123456789, 0);
    total++;
    if ({empty, dout, usage} !== {1'b0, 36'h123456789, 5'd1}) begin
      bad++; $display("FAIL flush_push got e=%b d=%h u=%0d want e=0 d=123456789 u=1", empty, dout, usage);
    end
  endtask

  task automatic test_reset_midread();
    cycle(1, 0, 0, '0, 0);
    cycle(0, 0, 0, '0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, rnd(), 0);
    cycle(0, 0, 0, '0, 1);
    cycle(1, 1, 1, rnd(), 1);
    total++;
    if ({empty, full, ae, af, ovf, unf, usage, dout} !== {6'b101000, 5'd0, 36'h0}) begin
      bad++; $display("FAIL reset_midread got e=%b u=%0d o=%b n=%b d=%h want e=1 u=0 o=0 n=0 d=0",
                      empty, usage, ovf, unf, dout);
    end
    cycle(0, 0, 1, 36'h77, 0);
    cycle(0, 0, 0, '0, 0);
    total++;
    if ({empty, dout, usage} !== {1'b0, 36'h77, 5'd1}) begin
      bad++; $display("FAIL midread_push got e=%b d=%h u=%0d want e=0 d=77 u=1", empty, dout, usage);
    end
  endtask

  task automatic test_random();
    int bias;
    cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 600; i++) begin
      bias = (i / 50) % 3;
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 79) == 0),
            ($urandom_range(0, 3) < 1 + bias), rnd(), ($urandom_range(0, 3) < 3 - bias));
      total++;
      if ({empty, full, ae, af, ovf, unf, usage} !== exp_stat() || dout !== m_head) begin
        bad++; $display("FAIL random i=%0d got=%b d=%h want=%b d=%h", i,
                        {empty, full, ae, af, ovf, unf, usage}, dout, exp_stat(), m_head);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_reset_midread();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_v4_sram.md
Name: fifo_v4_sram

Overview:
Synchronous first-word-fall-through FIFO built on an inferred simple-dual-port block RAM with one-cycle read latency, plus a 2-entry prefetch buffer.
- Sustains one push and one pop per cycle at any fill level.
- Adds parametrised width and depth, exact occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Drop-in buffer for the core's SRAM-backed queues.

Parameters:
DATA_WIDTH, 32, payload width in bits (1..1024).
DEPTH, 512, total capacity in entries; power of two, >= 4.
AF_THRESH, DEPTH-4, almost_full_o asserts when usage_o >= AF_THRESH.
AE_THRESH, 4, almost_empty_o asserts when usage_o <= AE_THRESH.
CNT_W, $clog2(DEPTH)+1, derived, do not override; occupancy width.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  reset, synchronous, active-high.
flush_i  in  1  synchronous clear of contents; errors preserved.
push_i  in  1  write request.
data_i  in  DATA_WIDTH  write data.
pop_i  in  1  read request; consumes head.
data_o  out  DATA_WIDTH  head entry, valid whenever empty_o=0.
empty_o  out  1  no entry at head.
full_o  out  1  usage_o == DEPTH.
almost_empty_o  out  1  usage_o <= AE_THRESH.
almost_full_o  out  1  usage_o >= AF_THRESH.
usage_o  out  CNT_W  entries held, 0..DEPTH inclusive.
overflow_o  out  1  sticky: push while full occurred.
underflow_o  out  1  sticky: pop while empty occurred.

Behaviour:
- Reset (rst_i=1 at edge): pointers, usage_o, prefetch buffer and error flags cleared.
  - Next cycle: empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, usage_o=0, overflow_o=0, underflow_o=0, data_o=0.
  - RAM contents are not reset.
  - Reset beats flush and any push/pop in the same cycle, including one mid-read.
- Flush: same clearing as reset except overflow_o/underflow_o hold. An in-flight RAM read is discarded. Flush beats same-cycle push/pop.
- Accept rules:
  - Push accepted iff push_i & ~full_o. A push while full is dropped, and overflow_o sets and stays set.
  - Pop accepted iff pop_i & ~empty_o. A pop while empty is ignored, and underflow_o sets and stays set.
  - Simultaneous accepted push+pop: usage_o unchanged, order preserved.
  - Push while full is rejected even with a same-cycle pop.
- usage_o counts RAM entries + in-flight read + prefetch entries. It updates the cycle after the accept: +1 push, -1 pop, 0 both.
- Flags derive combinationally from the registered usage_o, except empty_o, which reflects the prefetch head register.
- Datapath:
  - RAM write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Each cycle, a RAM read is issued iff the RAM is non-empty and (prefetch count + reads in flight) < 2, or a pop frees a slot this cycle.
  - Read data lands in the prefetch buffer one cycle later.
- Bypass: an accepted push goes straight into the prefetch buffer, never the RAM, iff the RAM is empty, no read is in flight, and the prefetch buffer has a free slot after this cycle's pop.
- Latency:
  - Push into an empty FIFO: empty_o=0 and data_o=data on the next cycle.
  - Entries routed through the RAM reach the head within 2 cycles of becoming eligible.
  - Continuous pop at full rate never stalls while usage_o >= 1.
- data_o is held stable while empty_o=0 and no pop occurs. When empty_o=1, data_o holds its last value.
- Ordering: strict FIFO across the bypass and RAM paths; no entry is duplicated or lost.

Decomposition:
- Package fifo_pkg: fifo_status_t struct (empty, full, almost_empty, almost_full, overflow, underflow) and the helper function cnt_w(depth).
- Sub-module sram_sdp #(WIDTH, DEPTH):
  - One write port, one read port, registered read, no reset on the array.
  - Inferable as BRAM; swappable for a vendor macro without touching FIFO control.
- Prefetch buffer and pointer/count logic stay in fifo_v4_sram.

Test Plan:
- Reset, then idle: empty_o=1, usage_o=0, almost_empty_o=1, flags 0. Single push 0xA5 -> next cycle empty_o=0, data_o=0xA5, usage_o=1.
- DATA_WIDTH=36, DEPTH=16, AF_THRESH=12, AE_THRESH=4: push 0..15 back-to-back -> almost_full_o rises when usage_o=12, full_o when usage_o=16. 17th push -> dropped, overflow_o=1, usage_o stays 16.
- From full, pop every cycle for 16 cycles -> data_o sequence 0..15 with no bubble; empty_o=1 after the last pop. One extra pop -> underflow_o=1.
- Simultaneous push/pop every cycle at usage_o=1, then at usage_o=8, for 100 cycles of random data -> usage_o constant, scoreboard order exact across bypass and RAM paths.
- Fill to 10, assert flush_i with push_i=1 and pop_i=1 -> next cycle usage_o=0, empty_o=1, sticky errors unchanged. A push afterwards returns its own data, never stale data.
- Reset asserted the cycle a RAM read is in flight at usage_o=5 -> next cycle usage_o=0, empty_o=1, errors cleared, no stale head appears.
